// File: rtl/floor_sched.sv
// Round-robin share of one fixed-latency floor unit; a result is visible LAT+1 cycles after accept.
// Requests stall while queued plus in-flight results would overfill the response FIFO; results never drop.

module floor_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop;

  assign head_vld = (count_q != '0);
  assign pop      = pop_rdy & head_vld;
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_vld) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_vld, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem_q[wr_ptr_q] <= push_dat;
  end

  // Upstream credit accounting makes this unreachable; a hit means the credit math is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push_vld && count_q == CNT_W'(DEPTH)));
endmodule

module floor_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_op,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          fl_op,
  input  logic [31:0]          fl_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 busy
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } rsp_t;

  tag_t             tag_q [LAT];
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  gnt;
  logic [ID_W-1:0]  scan_idx;
  logic             gnt_vld;
  logic             credit_ok;
  logic             accept;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] inflight;
  rsp_t             push_ent;
  rsp_t             head_ent;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + SUM_W'(tag_q[i].vld);
  end

  // A pop in this cycle is deliberately not credited: only registered occupancy counts.
  assign credit_ok = (SUM_W'(count) + inflight) < SUM_W'(DEPTH);

  always_comb begin
    gnt_vld  = 1'b0;
    gnt      = ptr_q;
    scan_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (!gnt_vld && req_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt     = scan_idx;
      end
    end
  end

  assign accept = gnt_vld & credit_ok & reset;

  always_comb begin
    req_ready = '0;
    fl_op     = 32'h0000_0000;
    for (int i = 0; i < N_REQ; i++) begin
      if (accept && gnt == ID_W'(i)) begin
        req_ready[i] = 1'b1;
        fl_op        = req_op[i*32 +: 32];
      end
    end
  end

  // Tags shift every cycle to mirror the floor unit, which has no stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= ID_W'(N_REQ - 1);
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      if (accept) ptr_q <= gnt;
      tag_q[0] <= '{vld: accept, id: gnt};
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign push_ent = '{id: tag_q[LAT-1].id, data: fl_result};

  floor_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (tag_q[LAT-1].vld),
    .push_dat (push_ent),
    .pop_rdy  (rsp_ready),
    .head_vld (rsp_valid),
    .head_dat (head_ent),
    .count    (count)
  );

  assign rsp_id   = head_ent.id;
  assign rsp_data = head_ent.data;
  assign busy     = (inflight != '0) || (count != '0);
endmodule

// File: tb/tb_floor_sched.sv
// Bench for floor_sched: 2-cycle floor unit stand-in, queue-based reference model, directed scenarios.
module tb_floor_sched;
  localparam int N = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [32*N-1:0] req_op = '0;
  logic [N-1:0]    req_ready;
  logic [31:0]     fl_op;
  logic [31:0]     fl_result;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_data;
  logic            busy;
  logic [31:0]     fl_s1 = '0;
  logic [31:0]     fl_s2 = '0;

  typedef struct { int id; logic [31:0] op; int vis; } ent_t;
  typedef struct { int id; logic [31:0] data; int cyc; } rec_t;

  ent_t mq[$];
  rec_t rsp_log[$];
  int   gnt_log[$];
  int   mptr = N - 1;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   acc;

  logic [31:0] stim [16];
  logic [31:0] int_f [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                              32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                              32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
  logic [31:0] neg_in  [3] = '{32'hBFC00000, 32'hBF000000, 32'hC0000000};
  logic [31:0] neg_out [3] = '{32'hC0000000, 32'hBF800000, 32'hC0000000};

  floor_sched #(.N_REQ(4), .ID_W(2), .DEPTH(4), .LAT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .fl_op     (fl_op),
    .fl_result (fl_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // binary32 floor from the IEEE encoding: clear fraction bits, bump magnitude for negatives.
  function automatic logic [31:0] floor_f32(input logic [31:0] x);
    int e;
    logic [31:0] mask;
    e = int'(x[30:23]);
    if (e >= 150) return x;
    if (e < 127) return x[31] ? ((x[30:0] == 31'h0) ? x : 32'hBF800000) : 32'h0;
    mask = (32'h1 << (150 - e)) - 32'h1;
    if ((x & mask) == 32'h0) return x;
    return x[31] ? ((x & ~mask) + (mask + 32'h1)) : (x & ~mask);
  endfunction

  always @(posedge clk) begin
    fl_s1 <= floor_f32(fl_op);
    fl_s2 <= fl_s1;
  end
  assign fl_result = fl_s2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : cmp
    int occ, g;
    bit found, ev;
    logic [N-1:0] er;
    logic [31:0] eop;
    if (!reset) begin
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      mq.delete();
      mptr = N - 1;
    end else begin
      occ = mq.size();
      found = 1'b0;
      g = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && req_valid[(mptr + k) % N]) begin
          found = 1'b1;
          g = (mptr + k) % N;
        end
      end
      er  = (found && occ < DEPTH) ? N'(1 << g) : '0;
      eop = (er != '0) ? req_op[g*32 +: 32] : 32'h0;
      ev  = (occ > 0) && (mq[0].vis <= cyc);
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("fl_op", fl_op, eop);
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(occ > 0));
      if (ev) begin
        chk("rsp_id", 32'(rsp_id), 32'(mq[0].id));
        chk("rsp_data", rsp_data, floor_f32(mq[0].op));
      end
      if (rsp_valid && rsp_ready) rsp_log.push_back('{int'(rsp_id), rsp_data, cyc});
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) gnt_log.push_back(i);
      if (ev && rsp_ready) void'(mq.pop_front());
      if (er != '0) begin
        mq.push_back('{g, eop, cyc + 3});
        mptr = g;
      end
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    req_valid = '0;
    tick;
    reset = 1'b1;
    rsp_log.delete();
    gnt_log.delete();
  endtask

  task automatic stream(input int r, input int start, input int n, input int budget,
                        output int accepted);
    int idx, t;
    idx = start;
    t = 0;
    while (idx < n && t < budget) begin
      req_valid[r] = 1'b1;
      req_op[r*32 +: 32] = stim[idx];
      @(negedge clk);
      if (req_ready[r]) idx++;
      tick;
      t++;
    end
    if (idx >= n) req_valid[r] = 1'b0;
    accepted = idx - start;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 32'(busy), 32'h0);
    tick;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation stalled at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single request from requester 2, fixed-cycle literal checks
    reset = 1'b0;
    repeat (3) tick;
    reset = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_op[95:64] = 32'h40200000;
    @(negedge clk);
    chk("t1_ready_c0", 32'(req_ready), 32'h4);
    tick;
    req_valid = '0;
    @(negedge clk);
    chk("t1_valid_c1", 32'(rsp_valid), 32'h0);
    tick;
    @(negedge clk);
    chk("t1_valid_c2", 32'(rsp_valid), 32'h0);
    tick;
    @(negedge clk);
    chk("t1_valid_c3", 32'(rsp_valid), 32'h1);
    chk("t1_id_c3", 32'(rsp_id), 32'h2);
    chk("t1_data_c3", rsp_data, 32'h40000000);
    tick;
    @(negedge clk);
    chk("t1_busy_c4", 32'(busy), 32'h0);
    tick;

    // Negative operands back-to-back from requester 0
    rsp_log.delete();
    for (int k = 0; k < 3; k++) stim[k] = neg_in[k];
    stream(0, 0, 3, 10, acc);
    chk("t2_accepts", acc, 3);
    wait_idle(20);
    chk("t2_count", rsp_log.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("t2_data", (k < rsp_log.size()) ? rsp_log[k].data : 32'hDEADDEAD, neg_out[k]);
      if (k > 0 && k < rsp_log.size())
        chk("t2_gap", rsp_log[k].cyc - rsp_log[k-1].cyc, 1);
    end

    // Fairness with all requesters asserted
    do_reset;
    req_op = {32'h40490FDB, 32'hC0490FDB, 32'h3F000000, 32'h41200000};
    req_valid = 4'hF;
    for (int t = 0; t < 40 && gnt_log.size() < 12; t++) tick;
    req_valid = '0;
    wait_idle(20);
    for (int k = 0; k < 12; k++) begin
      chk("t3_grant", (k < gnt_log.size()) ? gnt_log[k] : -1, k % 4);
      chk("t3_rsp_id", (k < rsp_log.size()) ? rsp_log[k].id : -1, k % 4);
    end
    chk("t3_pi_floor", (3 < rsp_log.size()) ? rsp_log[3].data : 32'hDEADDEAD, 32'h40400000);
    chk("t3_negpi_floor", (2 < rsp_log.size()) ? rsp_log[2].data : 32'hDEADDEAD, 32'hC0800000);

    // Credit stall with rsp_ready low, then drain
    do_reset;
    for (int k = 0; k < 16; k++) stim[k] = int_f[k];
    rsp_ready = 1'b0;
    stream(1, 0, 6, 10, acc);
    chk("t4_stall_accepts", acc, 4);
    @(negedge clk);
    chk("t4_ready_blocked", 32'(req_ready), 32'h0);
    tick;
    rsp_ready = 1'b1;
    stream(1, 4, 6, 20, acc);
    chk("t4_resume_accepts", acc, 2);
    wait_idle(20);
    chk("t4_count", rsp_log.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk("t4_id", (k < rsp_log.size()) ? rsp_log[k].id : -1, 1);
      chk("t4_data", (k < rsp_log.size()) ? rsp_log[k].data : 32'hDEADDEAD, int_f[k]);
    end

    // Reset one cycle after two acceptances
    do_reset;
    stim[0] = 32'h40F00000;
    stim[1] = 32'h41080000;
    stream(3, 0, 2, 5, acc);
    chk("t5_accepts", acc, 2);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_no_stale", 32'(rsp_valid), 32'h0);
      chk("t5_busy", 32'(busy), 32'h0);
      tick;
    end
    req_valid = 4'hF;
    @(negedge clk);
    chk("t5_first_grant", 32'(req_ready), 32'h1);
    tick;
    req_valid = '0;
    wait_idle(20);

    // Steady push/pop with two entries parked in the FIFO, across pointer wrap
    do_reset;
    for (int k = 0; k < 16; k++) stim[k] = int_f[k];
    rsp_ready = 1'b0;
    stream(0, 0, 2, 5, acc);
    chk("t6_prefill", acc, 2);
    repeat (3) tick;
    rsp_ready = 1'b1;
    stream(2, 2, 14, 60, acc);
    chk("t6_accepts", acc, 12);
    wait_idle(20);
    chk("t6_count", rsp_log.size(), 14);
    for (int k = 0; k < 14; k++) begin
      chk("t6_id", (k < rsp_log.size()) ? rsp_log[k].id : -1, (k < 2) ? 0 : 2);
      chk("t6_data", (k < rsp_log.size()) ? rsp_log[k].data : 32'hDEADDEAD, int_f[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
